// File: rtl/fpu_mul_ctrl.sv
// Purpose : control stage in front of the combinational fpu_mult core. It registers one
//           operand pair per handshake, waits a fixed settle window, captures the core
//           result and replaces it with IEEE special values (NaN/Inf/zero/OF/UF).
// Latency : out_valid rises exactly LATENCY cycles after the accepting edge, whatever the data.
// Backpr. : a single operation is in flight at a time. in_ready is high only in IDLE, and the
//           result and flags are held while out_ready is low.
// Ports   : clk/rst (synchronous, active-high). in_valid/in_ready/in_a/in_b carry the operand
//           handshake. mul_a/mul_b/mul_result connect to the core. out_valid/out_ready/
//           out_result/out_flags carry the result handshake, with flags = {NV, OF, UF}.
module fpu_mul_ctrl #(
    parameter int unsigned LATENCY = 1   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0]        res_q, res_d;
    logic [2:0]         flags_q, flags_d;
    // Special-case class captured with the operands. These values depend only on the
    // operands, so they can be evaluated at accept time and held for the whole window.
    logic               nv_q, nv_d, inf_q, inf_d, zero_q, zero_d, sign_q, sign_d;
    logic signed [9:0]  esum_q, esum_d;

    // Classify the incoming pair.
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        a_emax, b_emax;
    logic signed [9:0] in_esum;

    assign a_emax  = (in_a[30:23] == 8'hFF);
    assign b_emax  = (in_b[30:23] == 8'hFF);
    assign a_zero  = (in_a[30:23] == 8'h00);   // denormals are flushed to zero
    assign b_zero  = (in_b[30:23] == 8'h00);
    assign a_inf   = a_emax && (in_a[22:0] == 23'd0);
    assign b_inf   = b_emax && (in_b[22:0] == 23'd0);
    assign a_nan   = a_emax && (in_a[22:0] != 23'd0);
    assign b_nan   = b_emax && (in_b[22:0] != 23'd0);
    // The 10-bit signed sum covers -127..383, so it never wraps.
    assign in_esum = $signed({2'b00, in_a[30:23]}) + $signed({2'b00, in_b[30:23]}) - 10'sd127;

    // Final result selection, in priority order.
    logic [31:0] fin_res;
    logic [2:0]  fin_flags;

    always_comb begin
        fin_res   = mul_result;
        fin_flags = 3'b000;
        if (nv_q) begin
            fin_res   = QNAN;
            fin_flags = 3'b100;
        end else if (inf_q) begin
            fin_res   = {sign_q, 8'hFF, 23'd0};
        end else if (zero_q) begin
            fin_res   = {sign_q, 31'd0};
        end else if (esum_q <= 10'sd0) begin
            fin_res   = {sign_q, 31'd0};
            fin_flags = 3'b001;
        end else if (esum_q >= 10'sd255) begin
            fin_res   = {sign_q, 8'hFF, 23'd0};
            fin_flags = 3'b010;
        end else if ((esum_q == 10'sd254) && (mul_result[30:23] == 8'hFF)) begin
            // Mantissa carry pushed the core's exponent into the Inf/NaN encoding.
            fin_res   = {sign_q, 8'hFF, 23'd0};
            fin_flags = 3'b010;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        res_d   = res_q;
        flags_d = flags_q;
        nv_d    = nv_q;
        inf_d   = inf_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        esum_d  = esum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mul_a_d = in_a;
                    mul_b_d = in_b;
                    nv_d    = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
                    inf_d   = a_inf || b_inf;
                    zero_d  = a_zero || b_zero;
                    sign_d  = in_a[31] ^ in_b[31];
                    esum_d  = in_esum;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == 4'd0) begin
                    res_d   = fin_res;
                    flags_d = fin_flags;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            res_q   <= 32'd0;
            flags_q <= 3'b000;
            nv_q    <= 1'b0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            esum_q  <= 10'sd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            nv_q    <= nv_d;
            inf_q   <= inf_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            esum_q  <= esum_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign out_result = res_q;
    assign out_flags  = flags_q;

endmodule

// File: tb/tb_fpu_mul_ctrl.sv
module tb_fpu_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] in_a, in_b;

    logic        in_ready1, out_valid1, in_ready3, out_valid3;
    logic [31:0] mul_a1, mul_b1, mul_res1, out_result1;
    logic [31:0] mul_a3, mul_b3, mul_res3, out_result3;
    logic [2:0]  out_flags1, out_flags3;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Truncating behavioural model of the fpu_mult core (normal operands only).
    function automatic logic [31:0] core_model(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] frac;
        logic [31:0] ev;
        int          e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            frac = p[46:24];
            e    = e + 1;
        end else begin
            frac = p[45:23];
        end
        ev = e;
        return {a[31] ^ b[31], ev[7:0], frac};
    endfunction

    // Expected {flags, result} derived directly from the IEEE special-case rules.
    function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b);
        int   ea, eb, es;
        bit   za, zb, ia, ib, na, nb;
        logic s;
        logic [31:0] cm;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        es = ea + eb - 127;
        cm = core_model(a, b);
        if (na || nb || (ia && zb) || (za && ib)) return {3'b100, 32'h7FC00000};
        if (ia || ib)  return {3'b000, s, 8'hFF, 23'd0};
        if (za || zb)  return {3'b000, s, 31'd0};
        if (es <= 0)   return {3'b001, s, 31'd0};
        if (es >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (es == 254 && cm[30:23] == 8'hFF) return {3'b010, s, 8'hFF, 23'd0};
        return {3'b000, cm};
    endfunction

    assign mul_res1 = core_model(mul_a1, mul_b1);
    assign mul_res3 = core_model(mul_a3, mul_b3);

    fpu_mul_ctrl #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a1), .mul_b(mul_b1),
        .mul_result(mul_res1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_result(out_result1), .out_flags(out_flags1)
    );

    fpu_mul_ctrl #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a3), .mul_b(mul_b3),
        .mul_result(mul_res3), .out_valid(out_valid3), .out_ready(out_ready),
        .out_result(out_result3), .out_flags(out_flags3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Random operand biased toward the special classes and exponent extremes.
    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom % 8)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; f = 23'd0; end
            2:       begin e = 8'hFF; f = f | 23'd1; end
            3:       e = 8'($urandom_range(254, 200));
            4:       e = 8'($urandom_range(60, 1));
            default: e = 8'($urandom_range(154, 100));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Called just after a negedge with both DUTs idle; returns just after a negedge.
    // With chain=1 the next pair (na/nb) is held on the inputs with in_valid high through
    // the hold phase and the handshake, so it is accepted on the edge after returning.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          input bit chain, input logic [31:0] na, input logic [31:0] nb);
        logic [34:0] e;
        e = ref_model(a, b);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        chk("in_ready1_idle", {31'd0, in_ready1}, 32'd1);
        chk("in_ready3_idle", {31'd0, in_ready3}, 32'd1);
        @(negedge clk);
        // Junk on the input while busy must be ignored.
        in_valid = 1'($urandom); in_a = $urandom; in_b = $urandom;
        chk("out_valid1_k0", {31'd0, out_valid1}, 32'd0);
        chk("out_valid3_k0", {31'd0, out_valid3}, 32'd0);
        chk("in_ready1_busy", {31'd0, in_ready1}, 32'd0);
        chk("mul_a1_load", mul_a1, a);
        chk("mul_b3_load", mul_b3, b);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom); in_a = $urandom; in_b = $urandom;
            chk("out_valid1_lat", {31'd0, out_valid1}, 32'd1);
            chk("out_valid3_lat", {31'd0, out_valid3}, (k >= 3) ? 32'd1 : 32'd0);
            chk("in_ready3_busy", {31'd0, in_ready3}, 32'd0);
            chk("mul_a3_hold", mul_a3, a);
        end
        chk("result1", out_result1, e[31:0]);
        chk("flags1", {29'd0, out_flags1}, {29'd0, e[34:32]});
        chk("result3", out_result3, e[31:0]);
        chk("flags3", {29'd0, out_flags3}, {29'd0, e[34:32]});
        for (int h = 0; h < hold; h++) begin
            if (chain) begin in_a = na; in_b = nb; in_valid = 1'b1; end
            @(negedge clk);
            chk("hold_valid1", {31'd0, out_valid1}, 32'd1);
            chk("hold_valid3", {31'd0, out_valid3}, 32'd1);
            chk("hold_result1", out_result1, e[31:0]);
            chk("hold_flags3", {29'd0, out_flags3}, {29'd0, e[34:32]});
            chk("hold_in_ready1", {31'd0, in_ready1}, 32'd0);
            chk("hold_mul_a1", mul_a1, a);
        end
        out_ready = 1'b1;
        if (chain) begin in_a = na; in_b = nb; in_valid = 1'b1; end
        else in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid1", {31'd0, out_valid1}, 32'd0);
        chk("post_valid3", {31'd0, out_valid3}, 32'd0);
        chk("post_in_ready1", {31'd0, in_ready1}, 32'd1);
        chk("post_in_ready3", {31'd0, in_ready3}, 32'd1);
        chk("post_mul_a1", mul_a1, a);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
        chk("rst_in_ready3", {31'd0, in_ready3}, 32'd1);
        chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        chk("rst_out_valid3", {31'd0, out_valid3}, 32'd0);
        chk("rst_result1", out_result1, 32'd0);
        chk("rst_flags3", {29'd0, out_flags3}, 32'd0);
        chk("rst_mul_a1", mul_a1, 32'd0);
        chk("rst_mul_b3", mul_b3, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(32'h40000000, 32'h40400000, 0, 1'b0, 32'd0, 32'd0);
        run_op(32'h3F800000, 32'h3F800000, 5, 1'b1, 32'h7F800000, 32'h00000000);
        run_op(32'h7F800000, 32'h00000000, 0, 1'b0, 32'd0, 32'd0);
        run_op(32'hFF800000, 32'h40000000, 1, 1'b0, 32'd0, 32'd0);
        run_op(32'h7FC00001, 32'h3F800000, 0, 1'b0, 32'd0, 32'd0);
        run_op(32'h7F000000, 32'h3FC00000, 0, 1'b0, 32'd0, 32'd0);
        run_op(32'h7F400000, 32'h3FC00000, 0, 1'b0, 32'd0, 32'd0);
        run_op(32'h7F000000, 32'h7F000000, 0, 1'b0, 32'd0, 32'd0);
        run_op(32'h00800000, 32'h80800000, 0, 1'b0, 32'd0, 32'd0);
        run_op(32'h00000001, 32'h40000000, 0, 1'b0, 32'd0, 32'd0);

        // Random operands.
        for (int i = 0; i < 40; i++) begin
            run_op(rand_op(), rand_op(), int'($urandom_range(2, 0)), 1'b0, 32'd0, 32'd0);
        end

        // Reset while the LATENCY=3 instance is still in its settle window.
        in_a = 32'h3F800000; in_b = 32'h40000000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid3", {31'd0, out_valid3}, 32'd0);
        chk("mid_rst_ready3", {31'd0, in_ready3}, 32'd1);
        chk("mid_rst_mul_a3", mul_a3, 32'd0);
        chk("mid_rst_valid1", {31'd0, out_valid1}, 32'd0);
        chk("mid_rst_ready1", {31'd0, in_ready1}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_late_valid3", {31'd0, out_valid3}, 32'd0);
            chk("no_late_valid1", {31'd0, out_valid1}, 32'd0);
        end

        // The block must still work normally after the mid-operation reset.
        run_op(32'hC0000000, 32'h40400000, 1, 1'b0, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
